// File: rtl/data_mem_responder.sv
// data_mem_responder: word load/store responder with programmable wait states and a one-cycle response.
// Optional DMEM_ERR_CHECK_EN rejects misaligned or out-of-range accesses via resp_err.
module data_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      state, nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic        acc_we, enter;
   logic [31:0] acc_addr, acc_wdata;
   logic [AW-1:0] idx;
   logic [31:0] mem [DEPTH];
   logic        unused_ok;
   assign req_ready  = state == IDLE;
   assign busy       = state != IDLE;
   assign resp_valid = state == RESP;
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      unique case (state)
         IDLE: if (req_valid) begin
            nxt     = WAIT_CYCLES == 0 ? RESP : WAIT;
            cnt_nxt = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
         end
         WAIT: begin
            nxt     = cnt == 4'd0 ? RESP : WAIT;
            cnt_nxt = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
         end
         RESP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // With zero wait states the access happens on the accept edge, before capture lands.
   assign enter     = nxt == RESP;
   assign acc_we    = req_ready ? req_we : we_q;
   assign acc_addr  = req_ready ? req_addr : addr_q;
   assign acc_wdata = req_ready ? req_wdata : wdata_q;
   assign idx       = acc_addr[AW+1:2];
   assign unused_ok = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`ifdef DMEM_ERR_CHECK_EN
   logic acc_err, err_q;
   assign acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr >= 32'(DEPTH * 4));
   assign resp_err = err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= enter & acc_err;
   end
`else
   localparam logic acc_err = 1'b0;
   assign resp_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         resp_rdata <= 32'd0;
      end else begin
         state      <= nxt;
         cnt        <= cnt_nxt;
         if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         resp_rdata <= (enter && !acc_we && !acc_err) ? mem[idx] : 32'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n && enter && acc_we && !acc_err) mem[idx] <= acc_wdata;
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder with 2 and 0 wait states.
module tb_data_mem_responder;
   logic        clk = 0, rst_n = 0;
   logic        req_valid = 0, req_we = 0, req_ready, resp_valid, resp_err, busy;
   logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata;
   logic        v0 = 0, we0 = 0, r0, rv0, er0, b0;
   logic [31:0] a0 = 0, wd0 = 0, rd0;
   int          n_chk = 0, n_pass = 0;
`ifdef DMEM_ERR_CHECK_EN
   localparam logic M = 1'b1;
`else
   localparam logic M = 1'b0;
`endif
   always #5 clk = ~clk;
   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .busy(busy));
   data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0), .req_we(we0),
      .req_addr(a0), .req_wdata(wd0), .resp_valid(rv0), .resp_rdata(rd0),
      .resp_err(er0), .busy(b0));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask
   task automatic access(input string tag, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
      int k;
      @(negedge clk);
      chk({tag, " ready"}, req_ready, 1);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
      k = 1;
      while (!resp_valid && k < 10) begin
         chk({tag, " busy"}, busy, 1);
         @(negedge clk);
         k++;
      end
      chk({tag, " latency"}, k, 3);
      chk({tag, " rdata"}, resp_rdata, exp_rd);
      chk({tag, " err"}, resp_err, exp_err);
      chk({tag, " busy_resp"}, busy, 1);
      @(negedge clk);
      chk({tag, " pulse_end"}, resp_valid, 0);
      chk({tag, " idle"}, busy, 0);
   endtask
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst ready", req_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst valid", resp_valid, 0);
      chk("rst rdata", resp_rdata, 0);
      chk("rst err", resp_err, 0);
      rst_n = 1;
      @(negedge clk);
      chk("post ready", req_ready, 1);
      chk("post busy", busy, 0);
      access("st10", 1, 32'h10, 32'hDEADBEEF, 0, 0);
      access("ld10", 0, 32'h10, 0, 32'hDEADBEEF, 0);
      access("st0", 1, 32'h0, 32'hA5A5A5A5, 0, 0);
      access("st400", 1, 32'h400, 32'h11111111, 0, M);
      access("ld0", 0, 32'h0, 0, M ? 32'hA5A5A5A5 : 32'h11111111, 0);
      access("ld13", 0, 32'h13, 0, M ? 32'h0 : 32'hDEADBEEF, M);
      access("ld10b", 0, 32'h10, 0, 32'hDEADBEEF, 0);
      access("st8", 1, 32'h8, 32'h12345678, 0, 0);
      @(negedge clk);
      req_valid = 1; req_we = 1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      req_valid = 0;
      chk("mid busy", busy, 1);
      rst_n = 0;
      #1;
      chk("rst busy", busy, 0);
      chk("rst valid", resp_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst hold valid", resp_valid, 0);
      end
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post rst valid", resp_valid, 0);
      end
      access("ld8", 0, 32'h8, 0, 32'h12345678, 0);
      @(negedge clk);
      v0 = 1; a0 = 32'h20;
      for (int i = 0; i < 6; i++) begin
         chk("w0 ready", r0, 1);
         chk("w0 idle", rv0, 0);
         we0 = (i % 2 == 0);
         wd0 = (i % 2 == 0) ? 32'h1000 + i : 32'hFFFF0000;
         @(negedge clk);
         chk("w0 valid", rv0, 1);
         chk("w0 busy", b0, 1);
         chk("w0 rdata", rd0, (i % 2 == 0) ? 32'h0 : 32'h1000 + i - 1);
         chk("w0 err", er0, 0);
         @(negedge clk);
      end
      v0 = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
